// File: rtl/floor_slot_manager_if.sv
// rtl/floor_slot_manager_if.sv - pixel/frame bus between the VGA side and the floor slot manager
interface floor_slot_manager_if;
  logic        frame_clk;
  logic        scroll_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [2:0]  is_floor;
  logic [18:0] floor_read_address;
  logic        floor_hit_d2;

  modport master (
    output frame_clk, scroll_en, DrawX, DrawY,
    input  is_floor, floor_read_address, floor_hit_d2
  );

  modport slave (
    input  frame_clk, scroll_en, DrawX, DrawY,
    output is_floor, floor_read_address, floor_hit_d2
  );
endinterface

// File: rtl/floor_slot_manager.sv
// rtl/floor_slot_manager.sv - scrolling floor slots, LFSR respawn and per-pixel floor ROM addressing
module floor_slot_manager #(
  parameter int          NUM_FLOORS  = 6,
  parameter int          FLOOR_W     = 120,
  parameter int          FLOOR_H     = 20,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480,
  parameter int          SPACING     = 80,
  parameter int          SCROLL_STEP = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic Clk,
  input logic Reset_n,
  floor_slot_manager_if.slave bus
);

  localparam logic [9:0]  STEP_V      = 10'(SCROLL_STEP);
  localparam logic [9:0]  RESPAWN_ADD = 10'(NUM_FLOORS * SPACING - SCROLL_STEP);
  localparam logic [10:0] FLOOR_W_V   = 11'(FLOOR_W);
  localparam logic [10:0] FLOOR_H_V   = 11'(FLOOR_H);
  localparam logic [9:0]  SCREEN_H_V  = 10'(SCREEN_H);

  // Respawn x is a raw 9-bit LFSR slice, so the sprite must fit at x=511.
  generate
    if (SCREEN_W - FLOOR_W < 511) begin : g_bad_geometry
      $error("floor_slot_manager: respawn x range exceeds screen width");
    end
  endgenerate

  logic [9:0]  slot_x [NUM_FLOORS];
  logic [9:0]  slot_y [NUM_FLOORS];
  logic [2:0]  slot_t [NUM_FLOORS];
  logic [15:0] lfsr;
  logic        frame_clk_q;
  logic        tick;
  logic        lfsr_fb;
  logic        hit_q;

  function automatic logic [2:0] map_type(input logic [2:0] sel);
    case (sel)
      3'd1:        return 3'd2;
      3'd2:        return 3'd3;
      3'd3:        return 3'd4;
      3'd4, 3'd5:  return 3'd5;
      default:     return 3'd1;
    endcase
  endfunction

  assign tick    = bus.frame_clk & ~frame_clk_q;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_clk_q <= 1'b1;
      lfsr        <= LFSR_SEED;
      for (int i = 0; i < NUM_FLOORS; i++) begin
        slot_x[i] <= 10'(i * 100);
        slot_y[i] <= 10'(SPACING * (i + 1));
        slot_t[i] <= 3'd1;
      end
    end else begin
      frame_clk_q <= bus.frame_clk;
      if (tick) begin
        lfsr <= {lfsr[14:0], lfsr_fb};
        if (bus.scroll_en) begin
          // All slots expiring on this tick share the pre-advance LFSR value.
          for (int i = 0; i < NUM_FLOORS; i++) begin
            if (slot_y[i] >= STEP_V) begin
              slot_y[i] <= slot_y[i] - STEP_V;
            end else begin
              slot_y[i] <= slot_y[i] + RESPAWN_ADD;
              slot_x[i] <= {1'b0, lfsr[15:7]};
              slot_t[i] <= map_type(lfsr[2:0]);
            end
          end
        end
      end
    end
  end

  logic        hit;
  logic [2:0]  hit_t;
  logic [9:0]  hit_dx;
  logic [9:0]  hit_dy;
  logic [18:0] addr_next;

  always_comb begin
    hit    = 1'b0;
    hit_t  = 3'd0;
    hit_dx = 10'd0;
    hit_dy = 10'd0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (!hit &&
          ({1'b0, bus.DrawX} >= {1'b0, slot_x[i]}) &&
          ({1'b0, bus.DrawX} <  {1'b0, slot_x[i]} + FLOOR_W_V) &&
          ({1'b0, bus.DrawY} >= {1'b0, slot_y[i]}) &&
          ({1'b0, bus.DrawY} <  {1'b0, slot_y[i]} + FLOOR_H_V) &&
          (slot_y[i] < SCREEN_H_V)) begin
        hit    = 1'b1;
        hit_t  = slot_t[i];
        hit_dx = bus.DrawX - slot_x[i];
        hit_dy = bus.DrawY - slot_y[i];
      end
    end
    addr_next = 19'(hit_dy) * 19'(FLOOR_W) + 19'(hit_dx);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bus.is_floor           <= 3'd0;
      bus.floor_read_address <= 19'd0;
      hit_q                  <= 1'b0;
      bus.floor_hit_d2       <= 1'b0;
    end else begin
      bus.is_floor           <= hit ? hit_t : 3'd0;
      bus.floor_read_address <= hit ? addr_next : 19'd0;
      hit_q                  <= hit;
      bus.floor_hit_d2       <= hit_q;
    end
  end

endmodule

// File: tb/tb_floor_slot_manager.sv
// tb/tb_floor_slot_manager.sv - directed self-checking bench for floor_slot_manager
module tb_floor_slot_manager;

  logic Clk = 1'b0;
  logic Reset_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [15:0] m_lfsr;
  logic [15:0] pre;
  logic [9:0]  exp_x;
  logic [2:0]  exp_t;

  floor_slot_manager_if bus ();

  floor_slot_manager dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else pass_cnt++;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [2:0] exp_map(input logic [2:0] s);
    logic [2:0] tbl [8];
    tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd1, 3'd1};
    return tbl[s];
  endfunction

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk) bus.frame_clk = 1'b1;
      @(negedge Clk) bus.frame_clk = 1'b0;
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [2:0] t, input logic [18:0] a, input logic h);
    @(negedge Clk);
    bus.DrawX = x;
    bus.DrawY = y;
    @(negedge Clk);
    check({tag, ".is_floor"}, 32'(bus.is_floor), 32'(t));
    check({tag, ".addr"}, 32'(bus.floor_read_address), 32'(a));
    @(negedge Clk);
    check({tag, ".hit_d2"}, 32'(bus.floor_hit_d2), 32'(h));
  endtask

  initial begin
    Reset_n       = 1'b0;
    bus.frame_clk = 1'b0;
    bus.scroll_en = 1'b0;
    bus.DrawX     = 10'd5;
    bus.DrawY     = 10'd85;
    m_lfsr        = 16'hACE1;
    repeat (3) @(negedge Clk);
    check("rst.is_floor", 32'(bus.is_floor), 32'd0);
    check("rst.addr", 32'(bus.floor_read_address), 32'd0);
    check("rst.hit_d2", 32'(bus.floor_hit_d2), 32'd0);
    Reset_n = 1'b1;

    probe("t1", 10'd5, 10'd85, 3'd1, 19'd605, 1'b1);
    probe("t2.corner", 10'd119, 10'd99, 3'd1, 19'd2399, 1'b1);
    probe("t2.right_edge", 10'd120, 10'd85, 3'd0, 19'd0, 1'b0);
    probe("t2.bottom_edge", 10'd5, 10'd100, 3'd0, 19'd0, 1'b0);
    probe("t2.offscreen_slot", 10'd510, 10'd485, 3'd0, 19'd0, 1'b0);

    // Frame ticks without scroll only advance the LFSR
    pulse(10);
    probe("t4.slot0_top", 10'd5, 10'd80, 3'd1, 19'd5, 1'b1);
    probe("t4.above", 10'd5, 10'd79, 3'd0, 19'd0, 1'b0);

    bus.scroll_en = 1'b1;
    pulse(80);
    probe("t3.y0_drawn", 10'd5, 10'd0, 3'd1, 19'd5, 1'b1);
    pre = m_lfsr;
    pulse(1);
    exp_x = {1'b0, pre[15:7]};
    exp_t = exp_map(pre[2:0]);
    probe("t3.respawn", exp_x, 10'd479, exp_t, 19'd0, 1'b1);
    probe("t3.respawn_right", exp_x + 10'd119, 10'd479, exp_t, 19'd119, 1'b1);
    probe("t3.respawn_above", exp_x, 10'd478, 3'd0, 19'd0, 1'b0);
    probe("t3.slot1", 10'd100, 10'd79, 3'd1, 19'd0, 1'b1);

    // frame_clk high through reset release must not produce a tick
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    m_lfsr = 16'hACE1;
    repeat (50) @(negedge Clk);
    probe("t5.slot0", 10'd5, 10'd80, 3'd1, 19'd5, 1'b1);
    probe("t5.no_tick", 10'd5, 10'd79, 3'd0, 19'd0, 1'b0);
    bus.frame_clk = 1'b0;

    pulse(40);
    probe("t6.pre", 10'd5, 10'd40, 3'd1, 19'd5, 1'b1);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("t6.is_floor0", 32'(bus.is_floor), 32'd0);
    check("t6.hit_d2_0", 32'(bus.floor_hit_d2), 32'd0);
    @(negedge Clk);
    check("t6.is_floor1", 32'(bus.is_floor), 32'd0);
    check("t6.hit_d2_1", 32'(bus.floor_hit_d2), 32'd0);
    @(negedge Clk);
    check("t6.hit_d2_2", 32'(bus.floor_hit_d2), 32'd0);
    probe("t6.slot0", 10'd5, 10'd80, 3'd1, 19'd5, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
